// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Single-port data-memory arbiter between the MEM-stage CPU port and
//            an auxiliary master; AUX is forced a grant after STARVE_MAX CPU
//            wins. Optional build macro DMEM_ARB_PERF_EN adds perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int STARVE_MAX  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_stall_MEM,
    input  logic              i_aux_req,
    input  logic              i_aux_we,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [DATA_W-1:0] i_aux_wdata,
    output logic [DATA_W-1:0] o_aux_rdata,
    output logic              o_aux_ack,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic [DATA_W-1:0] i_mem_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [15:0]       o_aux_grant_cnt
`endif
);

    localparam logic [3:0] c_WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;      // 1 = AUX owns the access
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wait_q, wait_d;
    logic [3:0]          starve_q, starve_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;

    logic                w_grant;
    logic                w_grant_aux;
    logic                w_final;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= 4'd0;
            starve_q    <= 4'd0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        w_grant     = 1'b0;
        w_grant_aux = 1'b0;
        w_final     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_aux_req) begin
                    starve_d = 4'd0;
                end
                if (i_aux_req && (starve_q == c_STARVE_MAX)) begin
                    w_grant     = 1'b1;
                    w_grant_aux = 1'b1;
                    starve_d    = 4'd0;
                end else if (i_cpu_req) begin
                    w_grant = 1'b1;
                    if (i_aux_req && (starve_q < c_STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (i_aux_req) begin
                    w_grant     = 1'b1;
                    w_grant_aux = 1'b1;
                    starve_d    = 4'd0;
                end
            end
            ST_ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    w_final = 1'b1;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            aux_rdata_d = i_mem_data;
                        end else begin
                            cpu_rdata_d = i_mem_data;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The winner's request fields are captured so the requester may
        // drop or change them as soon as it sees its ack.
        if (w_grant) begin
            owner_d = w_grant_aux;
            we_d    = w_grant_aux ? i_aux_we    : i_cpu_we;
            addr_d  = w_grant_aux ? i_aux_addr  : i_cpu_addr;
            wdata_d = w_grant_aux ? i_aux_wdata : i_cpu_wdata;
            wait_d  = c_WAIT_INIT;
            state_d = ST_ACCESS;
        end
    end

    assign o_mem_write = w_final & we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_data  = wdata_q;
    assign o_cpu_ack   = (state_q == ST_DONE) & ~owner_q;
    assign o_aux_ack   = (state_q == ST_DONE) &  owner_q;
    assign o_cpu_rdata = cpu_rdata_q;
    assign o_aux_rdata = aux_rdata_q;
    assign o_stall_MEM = i_cpu_req & ~o_cpu_ack;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] aux_grant_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q     <= 32'd0;
            aux_grant_cnt_q <= 16'd0;
        end else begin
            if (o_stall_MEM && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (w_grant && w_grant_aux && (aux_grant_cnt_q != 16'hFFFF)) begin
                aux_grant_cnt_q <= aux_grant_cnt_q + 16'd1;
            end
        end
    end

    assign o_stall_cnt     = stall_cnt_q;
    assign o_aux_grant_cnt = aux_grant_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter (WAIT_CYCLES=0 and =2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic        d0_rst_n, d0_cpu_req, d0_cpu_we, d0_cpu_ack, d0_stall;
    logic [31:0] d0_cpu_addr, d0_cpu_wdata, d0_cpu_rdata;
    logic        d0_aux_req, d0_aux_we, d0_aux_ack;
    logic [31:0] d0_aux_addr, d0_aux_wdata, d0_aux_rdata;
    logic        d0_mem_write;
    logic [31:0] d0_mem_addr, d0_mem_wdata, d0_mem_rdata;

    logic        d2_rst_n, d2_cpu_req, d2_cpu_we, d2_cpu_ack, d2_stall;
    logic [31:0] d2_cpu_addr, d2_cpu_wdata, d2_cpu_rdata;
    logic        d2_aux_req, d2_aux_we, d2_aux_ack;
    logic [31:0] d2_aux_addr, d2_aux_wdata, d2_aux_rdata;
    logic        d2_mem_write;
    logic [31:0] d2_mem_addr, d2_mem_wdata, d2_mem_rdata;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] d0_stall_cnt, d2_stall_cnt;
    logic [15:0] d0_aux_gcnt, d2_aux_gcnt;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_MAX(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(d0_rst_n),
        .i_cpu_req(d0_cpu_req), .i_cpu_we(d0_cpu_we), .i_cpu_addr(d0_cpu_addr),
        .i_cpu_wdata(d0_cpu_wdata), .o_cpu_rdata(d0_cpu_rdata), .o_cpu_ack(d0_cpu_ack),
        .o_stall_MEM(d0_stall),
        .i_aux_req(d0_aux_req), .i_aux_we(d0_aux_we), .i_aux_addr(d0_aux_addr),
        .i_aux_wdata(d0_aux_wdata), .o_aux_rdata(d0_aux_rdata), .o_aux_ack(d0_aux_ack),
        .o_mem_write(d0_mem_write), .o_mem_addr(d0_mem_addr), .o_mem_data(d0_mem_wdata),
        .i_mem_data(d0_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .o_stall_cnt(d0_stall_cnt), .o_aux_grant_cnt(d0_aux_gcnt)
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2), .STARVE_MAX(4)) u_dut2 (
        .i_clk(clk), .i_rst_n(d2_rst_n),
        .i_cpu_req(d2_cpu_req), .i_cpu_we(d2_cpu_we), .i_cpu_addr(d2_cpu_addr),
        .i_cpu_wdata(d2_cpu_wdata), .o_cpu_rdata(d2_cpu_rdata), .o_cpu_ack(d2_cpu_ack),
        .o_stall_MEM(d2_stall),
        .i_aux_req(d2_aux_req), .i_aux_we(d2_aux_we), .i_aux_addr(d2_aux_addr),
        .i_aux_wdata(d2_aux_wdata), .o_aux_rdata(d2_aux_rdata), .o_aux_ack(d2_aux_ack),
        .o_mem_write(d2_mem_write), .o_mem_addr(d2_mem_addr), .o_mem_data(d2_mem_wdata),
        .i_mem_data(d2_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .o_stall_cnt(d2_stall_cnt), .o_aux_grant_cnt(d2_aux_gcnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: unwritten words read a fixed pattern, word 4 (0x10) is 0xDEADBEEF.
    bit [31:0] mem0 [64];
    bit        wr0  [64];
    bit [31:0] mem2 [64];
    bit        wr2  [64];

    function automatic logic [31:0] init_val(input int idx);
        return (idx == 4) ? 32'hDEAD_BEEF : (32'h1000_0000 | 32'(idx));
    endfunction

    always_comb d0_mem_rdata = wr0[d0_mem_addr[7:2]] ? mem0[d0_mem_addr[7:2]]
                                                     : init_val(int'(d0_mem_addr[7:2]));
    always_comb d2_mem_rdata = wr2[d2_mem_addr[7:2]] ? mem2[d2_mem_addr[7:2]]
                                                     : init_val(int'(d2_mem_addr[7:2]));

    always @(posedge clk) begin
        if (d0_mem_write) begin
            mem0[d0_mem_addr[7:2]] <= d0_mem_wdata;
            wr0[d0_mem_addr[7:2]]  <= 1'b1;
        end
        if (d2_mem_write) begin
            mem2[d2_mem_addr[7:2]] <= d2_mem_wdata;
            wr2[d2_mem_addr[7:2]]  <= 1'b1;
        end
    end

    // Port ids: 0 = DUT0 CPU, 1 = DUT0 AUX, 2 = DUT2 CPU, 3 = DUT2 AUX.
    typedef struct { int id; bit rd; logic [31:0] rdata; int cyc; } ack_t;
    typedef struct { int dut; logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
    ack_t qack[$];
    wr_t  qwr[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic see_ack(input int id, input logic [31:0] rdata);
        int   idx;
        ack_t e;
        idx = -1;
        for (int i = 0; i < qack.size(); i++) begin
            if (idx < 0 && qack[i].id == id) idx = i;
        end
        if (idx < 0) begin
            chk($sformatf("unexpected_ack_id%0d", id), 32'd1, 32'd0);
        end else begin
            e = qack[idx];
            qack.delete(idx);
            if (e.rd) chk($sformatf("rdata_id%0d", id), rdata, e.rdata);
            chk($sformatf("ack_cycle_id%0d", id), 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic see_wr(input int dut, input logic [31:0] addr, input logic [31:0] data);
        int  idx;
        wr_t e;
        idx = -1;
        for (int i = 0; i < qwr.size(); i++) begin
            if (idx < 0 && qwr[i].dut == dut) idx = i;
        end
        if (idx < 0) begin
            chk($sformatf("unexpected_write_dut%0d", dut), 32'd1, 32'd0);
        end else begin
            e = qwr[idx];
            qwr.delete(idx);
            chk($sformatf("wr_addr_dut%0d", dut), addr, e.addr);
            chk($sformatf("wr_data_dut%0d", dut), data, e.data);
            chk($sformatf("wr_cycle_dut%0d", dut), 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (d0_cpu_ack)   see_ack(0, d0_cpu_rdata);
        if (d0_aux_ack)   see_ack(1, d0_aux_rdata);
        if (d2_cpu_ack)   see_ack(2, d2_cpu_rdata);
        if (d2_aux_ack)   see_ack(3, d2_aux_rdata);
        if (d0_mem_write) see_wr(0, d0_mem_addr, d0_mem_wdata);
        if (d2_mem_write) see_wr(2, d2_mem_addr, d2_mem_wdata);
    end

    task automatic drive(input int id, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (id)
            0: begin d0_cpu_req = req; d0_cpu_we = we; d0_cpu_addr = addr; d0_cpu_wdata = wdata; end
            1: begin d0_aux_req = req; d0_aux_we = we; d0_aux_addr = addr; d0_aux_wdata = wdata; end
            2: begin d2_cpu_req = req; d2_cpu_we = we; d2_cpu_addr = addr; d2_cpu_wdata = wdata; end
            default: begin d2_aux_req = req; d2_aux_we = we; d2_aux_addr = addr; d2_aux_wdata = wdata; end
        endcase
    endtask

    function automatic logic ack_of(input int id);
        case (id)
            0:       return d0_cpu_ack;
            1:       return d0_aux_ack;
            2:       return d2_cpu_ack;
            default: return d2_aux_ack;
        endcase
    endfunction

    task automatic drop(input int id);
        drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Raise a request now, expect its ack 'lat' cycles later; leaves req high on return.
    task automatic access(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input int lat);
        logic got;
        got = 1'b0;
        qack.push_back('{id, !we, exp_rd, cyc + lat});
        if (we) qwr.push_back('{(id < 2) ? 0 : 2, addr, wdata, cyc + lat - 1});
        drive(id, 1'b1, we, addr, wdata);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = ack_of(id);
            if (id == 0) chk("stall_d0", 32'(d0_stall), 32'(!got));
            if (id == 2) chk("stall_d2", 32'(d2_stall), 32'(!got));
        end
        if (!got) chk($sformatf("ack_timeout_id%0d", id), 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        d0_rst_n = 1'b0;
        d2_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) drop(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_d0_cpu_ack",   32'(d0_cpu_ack), 32'd0);
        chk("rst_d0_mem_write", 32'(d0_mem_write), 32'd0);
        chk("rst_d0_mem_addr",  d0_mem_addr, 32'd0);
        chk("rst_d0_stall",     32'(d0_stall), 32'd0);
        chk("rst_d2_aux_ack",   32'(d2_aux_ack), 32'd0);
        chk("rst_d2_mem_data",  d2_mem_wdata, 32'd0);
        @(posedge clk); #1;
        d0_rst_n = 1'b1;
        d2_rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic read, write, AUX read-back on the zero-wait instance.
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2); drop(0);
        access(0, 1'b1, 32'h24, 32'hA5A5_0001, 32'h0, 2); drop(0);
        @(negedge clk);
        chk("mem_addr_hold", d0_mem_addr, 32'h24);
        chk("mem_data_hold", d0_mem_wdata, 32'hA5A5_0001);
        @(posedge clk); #1;
        access(1, 1'b0, 32'h24, 32'h0, 32'hA5A5_0001, 2); drop(1);
        @(posedge clk); #1;

        // Both masters saturate the port: four CPU grants, then AUX is forced in.
        fork
            begin
                access(0, 1'b0, 32'h00, 32'h0, 32'h1000_0000, 2);
                access(0, 1'b0, 32'h04, 32'h0, 32'h1000_0001, 2);
                access(0, 1'b0, 32'h08, 32'h0, 32'h1000_0002, 2);
                access(0, 1'b0, 32'h0C, 32'h0, 32'h1000_0003, 2);
                access(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 5);
                drop(0);
            end
            begin
                access(1, 1'b0, 32'h30, 32'h0, 32'h1000_000C, 14);
                access(1, 1'b0, 32'h34, 32'h0, 32'h1000_000D, 5);
                drop(1);
            end
        join
        @(posedge clk); #1;

        // CPU request arrives while an AUX write is in flight.
        fork
            begin
                access(1, 1'b1, 32'h28, 32'h0BAD_F00D, 32'h0, 2);
                drop(1);
            end
            begin
                @(posedge clk); #1;
                access(0, 1'b0, 32'h28, 32'h0, 32'h0BAD_F00D, 4);
                drop(0);
            end
        join

        // Two-wait-state instance: write then read back.
        access(2, 1'b1, 32'h20, 32'h1234_5678, 32'h0, 4); drop(2);
        access(2, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 4); drop(2);

        // Reset while a write is still counting down its wait states.
        drive(2, 1'b1, 1'b1, 32'h40, 32'hFFFF_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        d2_rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_cpu_ack",   32'(d2_cpu_ack), 32'd0);
        chk("rstmid_mem_write", 32'(d2_mem_write), 32'd0);
        chk("rstmid_mem_addr",  d2_mem_addr, 32'd0);
        chk("rstmid_mem_data",  d2_mem_wdata, 32'd0);
        chk("rstmid_cpu_rdata", d2_cpu_rdata, 32'd0);
        chk("rstmid_stall_req", 32'(d2_stall), 32'd1);
        @(posedge clk); #1;
        drop(2);
        @(negedge clk);
        chk("rstmid_stall_idle", 32'(d2_stall), 32'd0);
        @(posedge clk); #1;
        d2_rst_n = 1'b1;
        @(posedge clk); #1;

        // Three AUX reads with one CPU read arriving during the first AUX DONE.
        fork
            begin
                access(3, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 4);
                access(3, 1'b0, 32'h44, 32'h0, 32'h1000_0011, 9);
                access(3, 1'b0, 32'h48, 32'h0, 32'h1000_0012, 4);
                drop(3);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                access(2, 1'b0, 32'h04, 32'h0, 32'h1000_0001, 5);
                drop(2);
            end
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pending_acks",        32'(qack.size()), 32'd0);
        chk("pending_writes",      32'(qwr.size()), 32'd0);
        chk("aborted_write_mem",   32'(wr2[16]), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_aux_grant_cnt",  32'(d2_aux_gcnt), 32'd3);
        chk("perf_stall_cnt",      d2_stall_cnt, 32'd5);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
